// File: rtl/synth_tone_queue_if.sv
// Bundled SoC-side and voice-side signals of the tone-command queue.
// Optional macro SYNTH_QUEUE_OVF_CNT_EN adds the ovf_count status bus.
interface synth_tone_queue_if #(
    parameter int ADDR_W = 4
);
    logic              synth_en;
    logic              ld_fifo;
    logic [31:0]       tone;
    logic              flush;
    logic              sample_tick;
    logic              fifo_full;
    logic              run;
    logic              voice_wr;
    logic [2:0]        voice_idx;
    logic              voice_gate;
    logic [23:0]       voice_inc;
    logic [ADDR_W:0]   fifo_count;
`ifdef SYNTH_QUEUE_OVF_CNT_EN
    logic [15:0]       ovf_count;
`endif

    modport master (
        output synth_en, ld_fifo, tone, flush, sample_tick,
        input  fifo_full, run, voice_wr, voice_idx, voice_gate, voice_inc,
`ifdef SYNTH_QUEUE_OVF_CNT_EN
               ovf_count,
`endif
               fifo_count
    );

    modport slave (
        input  synth_en, ld_fifo, tone, flush, sample_tick,
        output fifo_full, run, voice_wr, voice_idx, voice_gate, voice_inc,
`ifdef SYNTH_QUEUE_OVF_CNT_EN
               ovf_count,
`endif
               fifo_count
    );
endinterface

// File: rtl/synth_tone_queue.sv
// Tone-command queue: buffers 32-bit tone words from the SoC and releases at
// most one decoded voice-register write per audio sample tick.
// Optional macro SYNTH_QUEUE_OVF_CNT_EN adds a saturating dropped-write counter.
module synth_tone_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int INC_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    synth_tone_queue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_TICK, POP, ISSUE} state_t;

    // Stored entry is {gate, idx, inc}; reserved tone bits are never kept.
    localparam int ENT_W = 4 + INC_W;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_nxt;
    state_t            state, state_nxt;
    logic              run_q;
    logic              full;
    logic              wr_acc;
    logic              do_pop;
    logic              v_gate;
    logic [2:0]        v_idx;
    logic [INC_W-1:0]  v_inc;
    logic              unused_rsvd;

    assign unused_rsvd = ^bus.tone[27:24];

    assign full   = (count == (ADDR_W+1)'(DEPTH));
    // A full queue drops the word even if a pop happens in the same cycle.
    assign wr_acc = bus.ld_fifo && !full && !bus.flush;
    assign do_pop = (state == POP) && !bus.flush;

    assign bus.fifo_full  = full;
    assign bus.fifo_count = count;
    assign bus.run        = run_q;
    assign bus.voice_wr   = (state == ISSUE);
    assign bus.voice_idx  = v_idx;
    assign bus.voice_gate = v_gate;
    assign bus.voice_inc  = v_inc;

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= {bus.tone[31:28], bus.tone[INC_W-1:0]};
    end

    // Occupancy next-value: flush wins, simultaneous write+pop cancels.
    always_comb begin
        count_nxt = count;
        if (bus.flush)
            count_nxt = '0;
        else if (wr_acc && !do_pop)
            count_nxt = count + (ADDR_W+1)'(1);
        else if (!wr_acc && do_pop)
            count_nxt = count - (ADDR_W+1)'(1);
    end

    // Pointers, occupancy, run register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            run_q  <= 1'b0;
        end else begin
            run_q <= bus.synth_en;
            count <= count_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered read of the head entry into the held voice fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_gate <= 1'b0;
            v_idx  <= '0;
            v_inc  <= '0;
        end else if (do_pop) begin
            {v_gate, v_idx, v_inc} <= mem[rd_ptr];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; ticks outside WAIT_TICK are simply not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (run_q) state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (!run_q)
                    state_nxt = IDLE;
                else if (bus.sample_tick && (count != '0))
                    state_nxt = POP;
            end
            POP:       state_nxt = ISSUE;
            ISSUE:     state_nxt = run_q ? WAIT_TICK : IDLE;
            default:   state_nxt = IDLE;
        endcase
        // An ISSUE cycle already drives voice_wr; flush only redirects the FSM.
        if (bus.flush) state_nxt = IDLE;
    end

`ifdef SYNTH_QUEUE_OVF_CNT_EN
    logic [15:0] ovf_q;
    assign bus.ovf_count = ovf_q;

    // Saturating count of words dropped because the queue was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_q <= '0;
        else if (bus.flush)
            ovf_q <= '0;
        else if (bus.ld_fifo && full && (ovf_q != 16'hFFFF))
            ovf_q <= ovf_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_synth_tone_queue.sv
// Directed bench for synth_tone_queue with a strobe scoreboard.
// Honors SYNTH_QUEUE_OVF_CNT_EN when the design is built with it.
module tb_synth_tone_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    synth_tone_queue_if #(.ADDR_W(4)) bus ();
    synth_tone_queue #(.DEPTH(16), .ADDR_W(4), .INC_W(24)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int nchk = 0;
    int nerr = 0;
    int nstb = 0;
    int mcnt = 0;
    int movf = 0;
    logic [27:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest accepted word.
    always @(negedge clk) begin
        if (bus.voice_wr === 1'b1) begin
            nstb++;
            if (q.size() == 0) begin
                nchk++;
                assert (q.size() != 0) else begin
                    nerr++;
                    $error("FAIL strobe_unexpected: got idx=%0h inc=%0h expected no strobe",
                           bus.voice_idx, bus.voice_inc);
                end
            end else begin
                chk("strobe_data", {4'h0, bus.voice_gate, bus.voice_idx, bus.voice_inc},
                    {4'h0, q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write one word; model accepts it if the queue was not full.
    task automatic wr(input logic [31:0] w);
        bus.ld_fifo = 1'b1;
        bus.tone    = w;
        if (mcnt < 16) begin
            q.push_back({w[31:28], w[23:0]});
            mcnt++;
        end else begin
            movf++;
        end
        step();
        bus.ld_fifo = 1'b0;
    endtask

    // One tick then enough cycles for POP and ISSUE to finish.
    task automatic tick(input bit expect_pop);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        step();
        if (expect_pop && mcnt > 0) mcnt--;
    endtask

    function automatic logic [31:0] mkw(input int i);
        logic [23:0] inc;
        inc = 24'(i * 24'h010101 + 24'h5);
        return {i[0], i[2:0], 4'hA, inc};
    endfunction

    initial begin
        int s0;
        bus.synth_en = 1'b0; bus.ld_fifo = 1'b0; bus.tone = '0;
        bus.flush = 1'b0; bus.sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_voice_wr", 32'(bus.voice_wr), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_run", 32'(bus.run), 32'd0);
        chk("rst_fields", {4'h0, bus.voice_gate, bus.voice_idx, bus.voice_inc}, 32'd0);
`ifdef SYNTH_QUEUE_OVF_CNT_EN
        chk("rst_ovf", 32'(bus.ovf_count), 32'd0);
`endif
        reset = 1'b0;
        step();
        bus.synth_en = 1'b1;
        step(); step();
        chk("run_up", 32'(bus.run), 32'd1);

        // Basic issue with exact latency.
        wr(32'h9200_1234);
        chk("basic_count1", 32'(bus.fifo_count), 32'd1);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        chk("basic_T1_no_wr", 32'(bus.voice_wr), 32'd0);
        step();
        chk("basic_T2_wr", 32'(bus.voice_wr), 32'd1);
        chk("basic_fields", {4'h0, bus.voice_gate, bus.voice_idx, bus.voice_inc}, 32'h0900_1234);
        step();
        mcnt--;
        chk("basic_wr_once", 32'(bus.voice_wr), 32'd0);
        chk("basic_count0", 32'(bus.fifo_count), 32'd0);
        chk("basic_hold", 32'(bus.voice_inc), 32'h1234);

        // Full, drop, and drain across the pointer wrap.
        for (int i = 0; i < 17; i++) begin
            wr(mkw(i));
            if (i == 14) chk("full_at15", 32'(bus.fifo_full), 32'd0);
            if (i == 15) chk("full_at16", 32'(bus.fifo_full), 32'd1);
        end
        chk("full_count16", 32'(bus.fifo_count), 32'd16);
`ifdef SYNTH_QUEUE_OVF_CNT_EN
        chk("ovf_1", 32'(bus.ovf_count), 32'(movf));
`endif
        s0 = nstb;
        repeat (16) tick(1);
        chk("drain_strobes", 32'(nstb - s0), 32'd16);
        chk("drain_count0", 32'(bus.fifo_count), 32'd0);
        chk("drain_full0", 32'(bus.fifo_full), 32'd0);

        // Empty tick, then a tick during POP is ignored.
        s0 = nstb;
        tick(0);
        chk("empty_tick", 32'(nstb - s0), 32'd0);
        wr(mkw(40)); wr(mkw(41));
        s0 = nstb;
        bus.sample_tick = 1'b1;
        step();
        step();
        bus.sample_tick = 1'b0;
        step(); step();
        mcnt--;
        chk("tick_in_pop_strobes", 32'(nstb - s0), 32'd1);
        chk("tick_in_pop_count", 32'(bus.fifo_count), 32'd1);
        tick(1);
        chk("tick_in_pop_drain", 32'(bus.fifo_count), 32'd0);

        // Simultaneous write and pop at count 5.
        for (int i = 0; i < 5; i++) wr(mkw(50 + i));
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        bus.ld_fifo = 1'b1;
        bus.tone = mkw(60);
        q.push_back({bus.tone[31:28], bus.tone[23:0]});
        step();
        bus.ld_fifo = 1'b0;
        chk("wr_pop_count5", 32'(bus.fifo_count), 32'd5);
        step();

        // Write at count 16 coincident with a pop is dropped.
        for (int i = 0; i < 11; i++) wr(mkw(70 + i));
        chk("wr_pop_full16", 32'(bus.fifo_count), 32'd16);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        bus.ld_fifo = 1'b1;
        bus.tone = mkw(99);
        movf++;
        step();
        bus.ld_fifo = 1'b0;
        chk("wr_pop_drop15", 32'(bus.fifo_count), 32'd15);
        step();
        mcnt = 15;
`ifdef SYNTH_QUEUE_OVF_CNT_EN
        chk("ovf_2", 32'(bus.ovf_count), 32'(movf));
`endif
        repeat (15) tick(1);
        chk("wr_pop_drain", 32'(bus.fifo_count), 32'd0);

        // Run drop retains entries; they resume when run returns.
        for (int i = 0; i < 3; i++) wr(mkw(110 + i));
        bus.synth_en = 1'b0;
        step(); step();
        s0 = nstb;
        repeat (3) tick(0);
        chk("rundrop_none", 32'(nstb - s0), 32'd0);
        chk("rundrop_kept", 32'(bus.fifo_count), 32'd3);
        bus.synth_en = 1'b1;
        step(); step();
        repeat (3) tick(1);
        chk("runup_strobes", 32'(nstb - s0), 32'd3);
        chk("runup_count0", 32'(bus.fifo_count), 32'd0);

        // Flush with 4 queued.
        for (int i = 0; i < 4; i++) wr(mkw(120 + i));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        repeat (4) void'(q.pop_back());
        mcnt = 0; movf = 0;
        chk("flush_count0", 32'(bus.fifo_count), 32'd0);
`ifdef SYNTH_QUEUE_OVF_CNT_EN
        chk("flush_ovf0", 32'(bus.ovf_count), 32'd0);
`endif
        s0 = nstb;
        step();
        repeat (2) tick(0);
        chk("flush_no_strobe", 32'(nstb - s0), 32'd0);
        chk("sb_empty", 32'(q.size()), 32'd0);

        // Reset asserted while in ISSUE clears outputs at once.
        wr(32'hF5AB_CDEF);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        chk("issue_before_rst", 32'(bus.voice_wr), 32'd1);
        reset = 1'b1;
        #1;
        q.delete();
        mcnt = 0;
        chk("midrst_voice_wr", 32'(bus.voice_wr), 32'd0);
        chk("midrst_fields", {4'h0, bus.voice_gate, bus.voice_idx, bus.voice_inc}, 32'd0);
        chk("midrst_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst_run", 32'(bus.run), 32'd0);
        step();
        reset = 1'b0;
        step(); step();
        chk("post_rst_count", 32'(bus.fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
